// File: rtl/pri_scan_encoder.sv
// Sequential priority scanner: accepts one multi-hot request vector and emits
// the index of each set bit, one per beat, MSB-first or LSB-first.
module pri_scan_encoder #(
  parameter  int WIDTH = 56,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int SEQ_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic [SEQ_W-1:0] out_seq
);

  localparam int PAD_W = 1 << IDX_W;

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] residual_reg, residual_next;
  logic             order_reg, order_next;
  logic [SEQ_W-1:0] seq_reg, seq_next;

  logic [PAD_W-1:0] pad_vec;
  logic [PAD_W-1:0] scan_vec;
  logic             top_vld;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] enc_idx;
  logic             single_bit;
  logic [WIDTH-1:0] clear_mask;

  always_comb begin
    pad_vec = '0;
    pad_vec[WIDTH-1:0] = residual_reg;
  end

  // LSB-first is handled by bit-reversing the padded vector and finding its
  // highest set bit; the reversed index is then the bitwise complement.
  genvar gi, gj;
  generate
    for (gi = 0; gi < PAD_W; gi++) begin : g_rev
      assign scan_vec[gi] = order_reg ? pad_vec[PAD_W-1-gi] : pad_vec[gi];
    end

    for (gi = 0; gi <= IDX_W; gi++) begin : g_lvl
      localparam int N = PAD_W >> gi;
      logic [N-1:0]            vld;
      logic [N-1:0][IDX_W-1:0] idx;
      if (gi == 0) begin : g_leaf
        assign vld = scan_vec;
        assign idx = '0;
      end else begin : g_merge
        for (gj = 0; gj < N; gj++) begin : g_node
          assign vld[gj] = g_lvl[gi-1].vld[2*gj+1] | g_lvl[gi-1].vld[2*gj];
          assign idx[gj] = g_lvl[gi-1].vld[2*gj+1]
                         ? (g_lvl[gi-1].idx[2*gj+1] | IDX_W'(1 << (gi - 1)))
                         : g_lvl[gi-1].idx[2*gj];
        end
      end
    end
  endgenerate

  assign top_vld    = g_lvl[IDX_W].vld[0];
  assign top_idx    = g_lvl[IDX_W].idx[0];
  assign enc_idx    = !top_vld ? '0 : (order_reg ? ~top_idx : top_idx);
  assign single_bit = ((residual_reg & (residual_reg - WIDTH'(1))) == '0);
  assign clear_mask = ~(WIDTH'(1) << enc_idx);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      residual_reg <= '0;
      order_reg    <= 1'b0;
      seq_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      residual_reg <= residual_next;
      order_reg    <= order_next;
      seq_reg      <= seq_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    residual_next = residual_reg;
    order_next    = order_reg;
    seq_next      = seq_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          state_next    = S_SCAN;
          residual_next = in_vec;
          order_next    = in_lsb_first;
          seq_next      = '0;
        end
      end
      S_SCAN: begin
        if (out_ready) begin
          if (single_bit) begin
            state_next    = S_IDLE;
            residual_next = '0;
            seq_next      = '0;
          end else begin
            residual_next = residual_reg & clear_mask;
            seq_next      = seq_reg + SEQ_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state
  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_SCAN);
    out_idx   = out_valid ? enc_idx : '0;
    out_last  = out_valid & single_bit;
    out_empty = out_valid & ~top_vld;
    out_seq   = seq_reg;
  end

endmodule

// File: tb/tb_pri_scan_encoder.sv
// Bench for pri_scan_encoder: a beat-list model checked every cycle, plus
// directed transactions with literal expectations.
module tb_pri_scan_encoder;
  localparam int W = 56;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_vec = '0;
  logic         in_lsb_first = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [5:0]   out_idx;
  logic         out_last;
  logic         out_empty;
  logic [5:0]   out_seq;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [5:0] idx;
    logic       last;
    logic       empty;
    logic [5:0] seq;
  } beat_t;

  beat_t mdl_q[$];
  beat_t cap_q[$];
  bit    mdl_init = 1'b0;

  pri_scan_encoder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_lsb_first(in_lsb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_empty(out_empty), .out_seq(out_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat list: every set bit in scan order, or a single empty beat.
  function automatic void mdl_load(logic [W-1:0] v, logic lsb);
    int n = $countones(v);
    int k = 0;
    if (n == 0) begin
      mdl_q.push_back(beat_t'{idx: 6'd0, last: 1'b1, empty: 1'b1, seq: 6'd0});
    end else begin
      for (int i = 0; i < W; i++) begin
        int b = lsb ? i : (W - 1 - i);
        if (v[b]) begin
          mdl_q.push_back(beat_t'{idx: 6'(b), last: (k == n - 1), empty: 1'b0, seq: 6'(k)});
          k++;
        end
      end
    end
  endfunction

  // Compare against the model mid-cycle, then advance the model by the
  // effect of the coming posedge.
  always @(negedge clk) begin
    if (mdl_init) begin
      chk("in_ready", in_ready, mdl_q.size() == 0);
      chk("out_valid", out_valid, mdl_q.size() != 0);
      if (mdl_q.size() != 0) begin
        chk("out_idx", out_idx, mdl_q[0].idx);
        chk("out_last", out_last, mdl_q[0].last);
        chk("out_empty", out_empty, mdl_q[0].empty);
        chk("out_seq", out_seq, mdl_q[0].seq);
      end else begin
        chk("idle_last", out_last, 0);
        chk("idle_empty", out_empty, 0);
      end
    end
    if (!rst && out_valid && out_ready)
      cap_q.push_back(beat_t'{idx: out_idx, last: out_last, empty: out_empty, seq: out_seq});
    if (rst) begin
      mdl_q.delete();
      mdl_init = 1'b1;
    end else if (mdl_init) begin
      if (mdl_q.size() != 0) begin
        if (out_ready) void'(mdl_q.pop_front());
      end else if (in_valid) begin
        mdl_load(in_vec, in_lsb_first);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 200; i++) begin
      if (in_ready && !out_valid) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for idle, got in_ready=%0b expected 1", name, in_ready);
  endtask

  task automatic send(logic [W-1:0] v, logic lsb);
    wait_idle("send_wait");
    in_valid = 1'b1;
    in_vec = v;
    in_lsb_first = lsb;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic log_txn(string name);
    $display("txn %s: %0d beats", name, cap_q.size());
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_seq", out_seq, 0);

    // All ones, MSB-first
    cap_q.delete();
    send({W{1'b1}}, 1'b0);
    wait_idle("t1");
    log_txn("all_ones_msb");
    chk("t1_count", cap_q.size(), 56);
    if (cap_q.size() == 56) begin
      chk("t1_first_idx", cap_q[0].idx, 55);
      chk("t1_final_idx", cap_q[55].idx, 0);
      chk("t1_final_seq", cap_q[55].seq, 55);
      chk("t1_final_last", cap_q[55].last, 1);
      chk("t1_prev_last", cap_q[54].last, 0);
    end

    // Empty vector
    cap_q.delete();
    send('0, 1'b0);
    wait_idle("t2");
    log_txn("empty");
    chk("t2_count", cap_q.size(), 1);
    if (cap_q.size() == 1) begin
      chk("t2_empty", cap_q[0].empty, 1);
      chk("t2_last", cap_q[0].last, 1);
      chk("t2_idx", cap_q[0].idx, 0);
      chk("t2_seq", cap_q[0].seq, 0);
    end

    // Two bits, LSB-first
    cap_q.delete();
    send(56'h00_8000_0000_0001, 1'b1);
    wait_idle("t3");
    log_txn("lsb_pair");
    chk("t3_count", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("t3_idx0", cap_q[0].idx, 0);
      chk("t3_last0", cap_q[0].last, 0);
      chk("t3_idx1", cap_q[1].idx, 47);
      chk("t3_seq1", cap_q[1].seq, 1);
      chk("t3_last1", cap_q[1].last, 1);
    end

    // Back-pressure while idx 10 is presented
    cap_q.delete();
    send((56'h1 << 55) | (56'h1 << 10) | (56'h1 << 3), 1'b0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_idx", out_idx, 10);
      chk("t4_hold_seq", out_seq, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t4");
    log_txn("stall");
    chk("t4_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("t4_idx1", cap_q[1].idx, 10);
      chk("t4_idx2", cap_q[2].idx, 3);
      chk("t4_last2", cap_q[2].last, 1);
    end

    // Reset mid-scan after idx 30 is accepted
    cap_q.delete();
    send((56'h1 << 40) | (56'h1 << 30) | (56'h1 << 20) | (56'h1 << 10) | (56'h1 << 5), 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ready", in_ready, 1);
    log_txn("reset_mid_scan");
    chk("t5_pre_count", cap_q.size(), 2);
    cap_q.delete();
    send(56'h3, 1'b0);
    wait_idle("t5b");
    log_txn("after_reset");
    chk("t5b_count", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("t5b_idx0", cap_q[0].idx, 1);
      chk("t5b_seq0", cap_q[0].seq, 0);
      chk("t5b_idx1", cap_q[1].idx, 0);
      chk("t5b_seq1", cap_q[1].seq, 1);
      chk("t5b_last1", cap_q[1].last, 1);
    end

    // in_valid held with a second vector during a scan
    cap_q.delete();
    wait_idle("t6_start");
    in_valid = 1'b1;
    in_vec = (56'h1 << 7) | (56'h1 << 5);
    in_lsb_first = 1'b0;
    tick();
    in_vec = 56'h1 << 50;
    chk("t6_busy0", in_ready, 0);
    tick();
    chk("t6_busy1", in_ready, 0);
    tick();
    chk("t6_bubble", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t6_second_valid", out_valid, 1);
    chk("t6_second_idx", out_idx, 50);
    wait_idle("t6");
    log_txn("held_valid");
    chk("t6_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("t6_idx0", cap_q[0].idx, 7);
      chk("t6_idx1", cap_q[1].idx, 5);
      chk("t6_last1", cap_q[1].last, 1);
      chk("t6_idx2", cap_q[2].idx, 50);
      chk("t6_seq2", cap_q[2].seq, 0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pri_scan_encoder.md
Name: pri_scan_encoder

Overview:
- Parametrised, sequential successor to the combinational MSB priority encoder.
- Accepts one WIDTH-bit request vector per transaction.
- Emits the index of every set bit, one per output beat, MSB-first or LSB-first per transaction, with valid/ready flow control on both sides.
- Used wherever a multi-hot vector (difference masks, request sets) must be serialised into indices.

Parameters:
WIDTH, 56, request vector width; any value >= 2, need not be a power of two
IDX_W, $clog2(WIDTH) (6), index width; derived, not overridden
SEQ_W, $clog2(WIDTH+1) (6), beat-sequence counter width; derived

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous active-high reset
in_valid  input  1  request vector offered
in_ready  output  1  block idle and able to accept
in_vec  input  WIDTH  request vector
in_lsb_first  input  1  scan order for this vector: 0 = MSB-first, 1 = LSB-first; sampled on accept
out_valid  output  1  out_idx/out_last/out_empty/out_seq valid
out_ready  input  1  consumer accepts beat
out_idx  output  IDX_W  index of current highest (or lowest) set bit
out_last  output  1  current beat is final beat of the vector
out_empty  output  1  accepted vector had no bits set (single beat)
out_seq  output  SEQ_W  beat number within the vector, 0-based

Behaviour:
- Reset (rst=1 at posedge): state IDLE, residual=0, seq=0, order=MSB. Outputs: out_valid=0, out_idx=0, out_last=0, out_empty=0, out_seq=0. in_ready=1 from the first cycle after reset.
- Reset mid-scan: pending residual is discarded and no further beats are produced. This overrides any simultaneous handshake.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at posedge: residual<=in_vec, order<=in_lsb_first, seq<=0, go SCAN.
- State SCAN:
  - in_ready=0; in_valid is ignored and no vector is lost or latched.
  - out_valid=1 in the cycle after acceptance (1-cycle latency).
  - out_idx = priority encode of residual: highest set bit if order=0, lowest set bit if order=1.
  - out_idx is a pure function of registered state. All outputs are stable while out_valid && !out_ready.
  - out_last = residual has at most one bit set.
  - out_empty = (residual==0). Only possible on beat 0; then out_idx=0 and out_last=1.
  - out_seq = seq.
- Beat handshake (out_valid && out_ready at posedge):
  - If out_last: go IDLE, residual<=0. in_ready=1 the next cycle; no same-cycle reload (one idle bubble per vector).
  - Otherwise: clear residual[out_idx], seq<=seq+1.
- Beat count: number of beats = popcount(in_vec), or 1 if in_vec==0. Maximum is WIDTH beats, seq max WIDTH-1.
- Encoder: log-depth tree over WIDTH padded to 2^IDX_W with zeros. Pad bits are never reported. Indices are always < WIDTH.
- Throughput: one index per cycle while out_ready=1. No back-to-back vector overlap.

Test Plan:
- WIDTH=56, in_vec all ones, MSB-first, out_ready=1 -> 56 beats; out_idx 55,54,...,0; out_seq 0..55; out_last only on idx 0; in_ready high the cycle after the last beat.
- in_vec=0 -> exactly one beat: out_empty=1, out_last=1, out_idx=0, out_seq=0; then IDLE.
- in_vec=56'h00_8000_0000_0001, in_lsb_first=1 -> beats idx 0 (seq 0, last=0), then idx 47 (seq 1, last=1).
- in_vec bits {55,10,3} MSB-first, out_ready low for 3 cycles while idx 10 is presented -> idx 10 and seq 1 held stable, then idx 3 last; no skip or duplicate.
- in_vec bits {40,30,20,10,5}; assert rst for 1 cycle after the beat with idx 30 is accepted -> next cycle out_valid=0, in_ready=1. New vector 56'h3 then yields idx 1 (seq 0), idx 0 (seq 1, last).
- in_valid held high with a different vector during a scan -> in_ready=0 throughout; the second vector is accepted only in the cycle after the first vector's last beat.
